// File: rtl/pipe_debug_ctrl_pkg.sv
// Shared encodings for the pipeline debug controller: commands, FSM states, halt causes.
package pipe_debug_ctrl_pkg;

  typedef enum logic [2:0] {
    CmdNop  = 3'd0,
    CmdRun  = 3'd1,
    CmdStep = 3'd2,
    CmdHalt = 3'd3,
    CmdClr  = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    StHalt  = 3'd0,
    StRun   = 3'd1,
    StStep  = 3'd2,
    StDrain = 3'd3
  } state_e;

  typedef enum logic [1:0] {
    CauseNone  = 2'd0,
    CauseCmd   = 2'd1,
    CauseBrk   = 2'd2,
    CauseInstr = 2'd3
  } cause_e;

  // Index width that stays at least one bit for single-entry cases.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_debug_ctrl_if.sv
// Debug command handshake and breakpoint write port of pipe_debug_ctrl.
interface pipe_debug_ctrl_if
  import pipe_debug_ctrl_pkg::*;
#(
  parameter int unsigned NB_BITS = 32,
  parameter int unsigned N_BRK   = 4
);
  localparam int unsigned IDX_W = idx_width(N_BRK);

  logic               i_cmd_valid;
  logic [2:0]         i_cmd;
  logic               o_cmd_ready;
  logic               o_cmd_err;
  logic               i_brk_wr;
  logic [IDX_W-1:0]   i_brk_idx;
  logic [NB_BITS-1:0] i_brk_addr;
  logic               i_brk_en;

  modport master (
    output i_cmd_valid, i_cmd, i_brk_wr, i_brk_idx, i_brk_addr, i_brk_en,
    input  o_cmd_ready, o_cmd_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_brk_wr, i_brk_idx, i_brk_addr, i_brk_en,
    output o_cmd_ready, o_cmd_err
  );
endinterface

// File: rtl/pipe_debug_ctrl_brk_cmp.sv
// Breakpoint comparator array: flags a hit when any enabled slot matches the fetch PC.
module brk_cmp #(
  parameter int unsigned N_BRK   = 4,
  parameter int unsigned NB_BITS = 32
) (
  input  logic [N_BRK-1:0][NB_BITS-1:0] i_addr,
  input  logic [N_BRK-1:0]              i_en,
  input  logic [NB_BITS-1:0]            i_pc,
  output logic                          o_hit
);

  always_comb begin
    o_hit = 1'b0;
    for (int i = 0; i < N_BRK; i++) begin
      o_hit = o_hit | (i_en[i] & (i_addr[i] == i_pc));
    end
  end

endmodule

// File: rtl/pipe_debug_ctrl.sv
// Pipeline run-control: RUN/STEP/HALT commands, PC breakpoints, halt-drain sequencing
// and saturating cycle/retire counters.
module pipe_debug_ctrl
  import pipe_debug_ctrl_pkg::*;
#(
  parameter int unsigned NB_BITS  = 32,
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned N_BRK    = 4,
  parameter int unsigned NB_CNT   = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  pipe_debug_ctrl_if.slave    dbg,
  input  logic [NB_BITS-1:0]  i_if_pc,
  input  logic                i_halt_instr,
  input  logic                i_wb_valid,
  output logic                o_pipe_en,
  output logic                o_pc_we,
  output logic                o_fetch_kill,
  output logic [2:0]          o_state,
  output logic                o_halted,
  output logic [1:0]          o_halt_cause,
  output logic [NB_CNT-1:0]   o_cycle_cnt,
  output logic [NB_CNT-1:0]   o_retire_cnt
);

  localparam int unsigned IDX_W   = idx_width(N_BRK);
  localparam int unsigned DRAIN_W = idx_width(N_STAGES);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(N_STAGES - 1);

  state_e               state_q, state_d;
  cause_e               cause_q, cause_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 first_run_q, first_run_d;
  logic                 cmd_err_q, cmd_err_d;
  logic                 clr_cnt;
  logic [NB_CNT-1:0]    cycle_cnt_q, retire_cnt_q;

  logic [N_BRK-1:0][NB_BITS-1:0] brk_addr_q;
  logic [N_BRK-1:0]              brk_en_q;
  logic                          brk_hit;
  logic                          halt_cmd;

  brk_cmp #(
    .N_BRK   (N_BRK),
    .NB_BITS (NB_BITS)
  ) u_brk_cmp (
    .i_addr (brk_addr_q),
    .i_en   (brk_en_q),
    .i_pc   (i_if_pc),
    .o_hit  (brk_hit)
  );

  assign halt_cmd = dbg.i_cmd_valid && (dbg.i_cmd == CmdHalt);

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    drain_d     = drain_q;
    first_run_d = 1'b0;
    cmd_err_d   = 1'b0;
    clr_cnt     = 1'b0;
    unique case (state_q)
      StHalt: begin
        if (dbg.i_cmd_valid) begin
          unique case (dbg.i_cmd)
            CmdNop:  ;
            CmdRun: begin
              state_d     = StRun;
              first_run_d = 1'b1;
            end
            CmdStep: state_d   = StStep;
            CmdClr:  clr_cnt   = 1'b1;
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      StRun: begin
        if (dbg.i_cmd_valid && (dbg.i_cmd != CmdNop) && (dbg.i_cmd != CmdHalt)) begin
          cmd_err_d = 1'b1;
        end
        // Match is masked on the first cycle so a resume from a breakpoint PC can advance.
        if (brk_hit && !first_run_q) begin
          state_d = StDrain;
          cause_d = CauseBrk;
        end else if (i_halt_instr) begin
          state_d = StDrain;
          cause_d = CauseInstr;
        end else if (halt_cmd) begin
          state_d = StDrain;
          cause_d = CauseCmd;
        end
        if (state_d == StDrain) drain_d = DRAIN_LOAD;
      end
      StStep: begin
        state_d = StHalt;
        cause_d = CauseNone;
      end
      StDrain: begin
        if (drain_q <= DRAIN_W'(1)) state_d = StHalt;
        if (drain_q != '0) drain_d = drain_q - 1'b1;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StHalt;
      cause_q     <= CauseNone;
      drain_q     <= '0;
      first_run_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      drain_q     <= drain_d;
      first_run_q <= first_run_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || clr_cnt) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      if (o_pipe_en && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (o_pipe_en && i_wb_valid && (retire_cnt_q != '1)) retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      brk_addr_q <= '0;
      brk_en_q   <= '0;
    end else if (dbg.i_brk_wr) begin
      for (int i = 0; i < N_BRK; i++) begin
        if (dbg.i_brk_idx == IDX_W'(i)) begin
          brk_addr_q[i] <= dbg.i_brk_addr;
          brk_en_q[i]   <= dbg.i_brk_en;
        end
      end
    end
  end

  assign o_pipe_en       = (state_q != StHalt);
  assign o_pc_we         = (state_q == StRun) || (state_q == StStep);
  assign o_fetch_kill    = (state_q == StDrain);
  assign o_halted        = (state_q == StHalt);
  assign o_state         = state_q;
  assign o_halt_cause    = cause_q;
  assign o_cycle_cnt     = cycle_cnt_q;
  assign o_retire_cnt    = retire_cnt_q;
  assign dbg.o_cmd_ready = (state_q == StHalt) || (state_q == StRun);
  assign dbg.o_cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_pipe_debug_ctrl.sv
// Directed self-checking bench for pipe_debug_ctrl (default config plus a 4-bit counter config).
module tb_pipe_debug_ctrl;
  import pipe_debug_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default parameters
  logic        rst_a;
  logic [31:0] pc_a;
  logic        hi_a, wb_a;
  logic        pe_a, pcwe_a, kill_a, hlt_a;
  logic [2:0]  st_a;
  logic [1:0]  cause_a;
  logic [31:0] cyc_a, ret_a;

  pipe_debug_ctrl_if #(.NB_BITS(32), .N_BRK(4)) dbg_a ();

  pipe_debug_ctrl u_dut (
    .i_clk        (clk),
    .i_rst        (rst_a),
    .dbg          (dbg_a.slave),
    .i_if_pc      (pc_a),
    .i_halt_instr (hi_a),
    .i_wb_valid   (wb_a),
    .o_pipe_en    (pe_a),
    .o_pc_we      (pcwe_a),
    .o_fetch_kill (kill_a),
    .o_state      (st_a),
    .o_halted     (hlt_a),
    .o_halt_cause (cause_a),
    .o_cycle_cnt  (cyc_a),
    .o_retire_cnt (ret_a)
  );

  // Instance B: 4-bit counters for saturation
  logic        rst_b;
  logic        pe_b, pcwe_b, kill_b, hlt_b;
  logic [2:0]  st_b;
  logic [1:0]  cause_b;
  logic [3:0]  cyc_b, ret_b;

  pipe_debug_ctrl_if #(.NB_BITS(32), .N_BRK(4)) dbg_b ();

  pipe_debug_ctrl #(.NB_CNT(4)) u_dut_b (
    .i_clk        (clk),
    .i_rst        (rst_b),
    .dbg          (dbg_b.slave),
    .i_if_pc      (32'h0),
    .i_halt_instr (1'b0),
    .i_wb_valid   (1'b0),
    .o_pipe_en    (pe_b),
    .o_pc_we      (pcwe_b),
    .o_fetch_kill (kill_b),
    .o_state      (st_b),
    .o_halted     (hlt_b),
    .o_halt_cause (cause_b),
    .o_cycle_cnt  (cyc_b),
    .o_retire_cnt (ret_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd_a(input cmd_e c);
    dbg_a.i_cmd_valid = 1'b1;
    dbg_a.i_cmd       = c;
    tick();
    dbg_a.i_cmd_valid = 1'b0;
    dbg_a.i_cmd       = CmdNop;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    pc_a = 32'h0; hi_a = 1'b0; wb_a = 1'b0;
    dbg_a.i_cmd_valid = 1'b0; dbg_a.i_cmd = CmdNop; dbg_a.i_brk_wr = 1'b0;
    dbg_a.i_brk_idx = '0; dbg_a.i_brk_addr = '0; dbg_a.i_brk_en = 1'b0;
    dbg_b.i_cmd_valid = 1'b0; dbg_b.i_cmd = CmdNop; dbg_b.i_brk_wr = 1'b0;
    dbg_b.i_brk_idx = '0; dbg_b.i_brk_addr = '0; dbg_b.i_brk_en = 1'b0;
    tick(); tick();
    rst_a = 1'b0;

    // Reset state
    check("rst_state", st_a, StHalt);
    check("rst_halted", hlt_a, 1);
    check("rst_pipe_en", pe_a, 0);
    check("rst_cycle", cyc_a, 0);
    check("rst_retire", ret_a, 0);
    check("rst_ready", dbg_a.o_cmd_ready, 1);
    check("rst_err", dbg_a.o_cmd_err, 0);

    // RUN, 10 cycles, retire only counted while enabled
    wb_a = 1'b1;
    cmd_a(CmdRun);
    check("run_pipe_en", pe_a, 1);
    check("run_pc_we", pcwe_a, 1);
    check("run_cycle0", cyc_a, 0);
    for (int i = 0; i < 10; i++) begin
      wb_a = (i < 3);
      tick();
    end
    wb_a = 1'b0;
    check("run_cycle10", cyc_a, 10);
    check("run_retire", ret_a, 3);

    // HALT command -> 4 drain cycles
    cmd_a(CmdHalt);
    check("hcmd_state", st_a, StDrain);
    check("hcmd_cause", cause_a, CauseCmd);
    check("hcmd_pc_we", pcwe_a, 0);
    check("hcmd_ready", dbg_a.o_cmd_ready, 0);
    for (int i = 0; i < 4; i++) begin
      check("hcmd_kill", kill_a, 1);
      tick();
    end
    check("hcmd_halted", hlt_a, 1);
    check("hcmd_kill_off", kill_a, 0);
    check("hcmd_cycle", cyc_a, 15);

    // HALT in HALT is illegal
    cmd_a(CmdHalt);
    check("halt_err", dbg_a.o_cmd_err, 1);
    tick();
    check("halt_err_pulse", dbg_a.o_cmd_err, 0);

    // CLR
    cmd_a(CmdClr);
    check("clr_cycle", cyc_a, 0);
    check("clr_retire", ret_a, 0);
    check("clr_state", st_a, StHalt);

    // Breakpoint slot 0 at 0x40
    dbg_a.i_brk_wr = 1'b1; dbg_a.i_brk_idx = 2'd0;
    dbg_a.i_brk_addr = 32'h40; dbg_a.i_brk_en = 1'b1;
    tick();
    dbg_a.i_brk_wr = 1'b0;
    pc_a = 32'h10;
    cmd_a(CmdRun);
    tick(); tick();
    check("brk_nohit", st_a, StRun);
    pc_a = 32'h40;
    tick();
    check("brk_state", st_a, StDrain);
    check("brk_pc_we", pcwe_a, 0);
    for (int i = 0; i < 4; i++) begin
      check("brk_kill", kill_a, 1);
      tick();
    end
    check("brk_halted", hlt_a, 1);
    check("brk_cause", cause_a, CauseBrk);

    // Resume from breakpoint PC
    cmd_a(CmdRun);
    check("resume_run", st_a, StRun);
    tick();
    check("resume_no_rehalt", st_a, StRun);
    check("resume_pc_we", pcwe_a, 1);
    pc_a = 32'h44;
    tick();
    check("resume_adv", st_a, StRun);
    cmd_a(CmdHalt);
    for (int i = 0; i < 4; i++) tick();
    check("resume_halted", hlt_a, 1);

    // STEP ignores halt sources
    cmd_a(CmdClr);
    pc_a = 32'h40; hi_a = 1'b1;
    cmd_a(CmdStep);
    check("step_state", st_a, StStep);
    check("step_pipe_en", pe_a, 1);
    check("step_ready", dbg_a.o_cmd_ready, 0);
    tick();
    hi_a = 1'b0;
    check("step_halted", hlt_a, 1);
    check("step_pipe_off", pe_a, 0);
    check("step_cause", cause_a, CauseNone);
    check("step_cycle", cyc_a, 1);

    // STEP in RUN is illegal
    pc_a = 32'h10;
    cmd_a(CmdRun);
    cmd_a(CmdStep);
    check("rstep_err", dbg_a.o_cmd_err, 1);
    check("rstep_state", st_a, StRun);
    tick();
    check("rstep_err_pulse", dbg_a.o_cmd_err, 0);

    // All three halt sources at once
    pc_a = 32'h40; hi_a = 1'b1;
    cmd_a(CmdHalt);
    pc_a = 32'h10; hi_a = 1'b0;
    check("prio_state", st_a, StDrain);
    check("prio_cause", cause_a, CauseBrk);
    tick();

    // Reset mid-drain
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("mrst_state", st_a, StHalt);
    check("mrst_cycle", cyc_a, 0);
    check("mrst_retire", ret_a, 0);
    check("mrst_cause", cause_a, CauseNone);
    pc_a = 32'h40;
    cmd_a(CmdRun);
    tick(); tick();
    check("mrst_brk_off", st_a, StRun);

    // INSTR outranks CMD
    hi_a = 1'b1;
    cmd_a(CmdHalt);
    hi_a = 1'b0;
    check("instr_cause", cause_a, CauseInstr);

    // Counter saturation on 4-bit instance
    rst_b = 1'b0;
    dbg_b.i_cmd_valid = 1'b1; dbg_b.i_cmd = CmdRun;
    tick();
    dbg_b.i_cmd_valid = 1'b0; dbg_b.i_cmd = CmdNop;
    check("sat_run", st_b, StRun);
    for (int i = 0; i < 20; i++) tick();
    check("sat_cycle", cyc_b, 4'hf);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_debug_ctrl.md
PIPE_DEBUG_CTRL -- requirements
Module: pipe_debug_ctrl

Interface
REQ-001 SHALL have parameter NB_BITS, 32, PC and breakpoint address width.
REQ-002 SHALL have parameter N_STAGES, 5, pipeline depth; sets drain length.
REQ-003 SHALL have parameter N_BRK, 4, number of PC breakpoints (1..16).
REQ-004 SHALL have parameter NB_CNT, 32, cycle and retire counter width.
REQ-005 SHALL use one clock; reset is synchronous and active-high: i_clk  in  1  clock; i_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have ports:
- i_cmd_valid  in  1  command strobe
- i_cmd  in  3  0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 CLR
- o_cmd_ready  out  1  command accepted when valid&ready
- o_cmd_err  out  1  one-cycle pulse for a command illegal in the current state
- i_brk_wr  in  1  breakpoint write strobe
- i_brk_idx  in  clog2(N_BRK)  breakpoint slot
- i_brk_addr  in  NB_BITS  breakpoint PC
- i_brk_en  in  1  slot enable written with address
- i_if_pc  in  NB_BITS  PC presented to fetch
- i_halt_instr  in  1  halt opcode decoded in IF/ID
- i_wb_valid  in  1  instruction retired in write-back
- o_pipe_en  out  1  global stage enable
- o_pc_we  out  1  PC write enable
- o_fetch_kill  out  1  force bubble into IF/ID
- o_state  out  3  FSM state
- o_halted  out  1  state == HALT
- o_halt_cause  out  2  0 STEP/none, 1 CMD, 2 BRK, 3 INSTR
- o_cycle_cnt  out  NB_CNT  enabled-cycle count
- o_retire_cnt  out  NB_CNT  retired-instruction count

Function
REQ-007 SHALL implement states HALT, RUN, STEP, DRAIN; outputs decoded from the registered state.
REQ-008 SHALL drive o_pipe_en=1 in RUN, STEP and DRAIN; 0 in HALT.
REQ-009 SHALL drive o_pc_we=1 only in RUN and STEP; o_fetch_kill=1 only in DRAIN.
REQ-010 SHALL assert o_cmd_ready in HALT and RUN only; accepted command changes state on the next edge.
REQ-011 HALT: RUN -> RUN; STEP -> STEP; CLR -> zero both counters, stay HALT; HALT -> o_cmd_err; NOP -> no effect.
REQ-012 RUN: HALT cmd -> DRAIN, cause CMD; RUN, STEP, CLR -> o_cmd_err, no state change.
REQ-013 STEP SHALL last exactly one cycle, then HALT with cause 0; breakpoints and i_halt_instr ignored in STEP.
REQ-014 In RUN, breakpoint hit = any enabled slot with address == i_if_pc; hit or i_halt_instr -> DRAIN.
REQ-015 SHALL suppress breakpoint matching in the first RUN cycle after leaving HALT, so resume from a breakpoint PC progresses.
REQ-016 Simultaneous halt sources SHALL record cause priority BRK > INSTR > CMD.
REQ-017 DRAIN SHALL load a down-counter with N_STAGES-1, decrement each cycle, and enter HALT the cycle after it reaches 0; new halt sources ignored.
REQ-018 o_cycle_cnt SHALL increment on every cycle with o_pipe_en=1 and saturate at all-ones.
REQ-019 o_retire_cnt SHALL increment when i_wb_valid & o_pipe_en and saturate at all-ones.
REQ-020 Breakpoint writes SHALL be accepted in any state and take effect on the next cycle's compare.

Reset
REQ-021 i_rst SHALL force state HALT, cause 0, counters 0, drain counter 0, all breakpoint enables 0, o_cmd_err 0, in any state including mid-DRAIN.
REQ-022 Breakpoint addresses SHALL reset to 0.

Structure
REQ-023 Command, state and cause encodings SHALL be defined as constants in the shared include file.
REQ-024 The breakpoint comparator array SHALL be a sub-module brk_cmp (N_BRK, NB_BITS) producing one hit bit.

Verification
REQ-025 Reset, then RUN cmd -> o_pipe_en=1 next cycle; 10 cycles later o_cycle_cnt=10.
REQ-026 Slot 0 = 0x40 enabled, RUN, i_if_pc reaches 0x40 -> o_pc_we=0, o_fetch_kill=1 for 4 cycles, then o_halted=1, cause 2.
REQ-027 RUN from HALT with i_if_pc=0x40 still matching -> no re-halt on first cycle; PC advances.
REQ-028 STEP in HALT -> o_pipe_en high exactly 1 cycle, cycle count +1, cause 0; STEP in RUN -> o_cmd_err pulse.
REQ-029 Same cycle: HALT cmd, i_halt_instr and breakpoint hit -> cause 2; NB_CNT=4 run 20 cycles -> o_cycle_cnt=15.
REQ-030 i_rst asserted during DRAIN -> next cycle HALT, counters 0, breakpoints disabled.
